mem_arbiter: RTL

Sequencer and arbiter for the single shared `memory4c` main memory. Three requesters share it: the I-cache fill path, the D-cache fill path and the D-cache write-through path. The block grants one requester at a time, issues the 8 pipelined word reads of a 16-byte block fill and steers returning words into the owning cache's data array. At fill completion it pulses a tag write. It sits between the two cache fill FSMs and `memory4c`, and drives `fsm_busy` to stall the pipeline.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/mem_arb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill path and main-memory arbiter.
// Block geometry, arbiter state encoding and requester identity live here.
package cache_pkg;

  localparam int WORDS    = 8;
  localparam int LATENCY  = 4;
  localparam int OFFSET_W = 4;
  localparam int WORD_W   = 3;

  // issue_cnt runs 0..WORDS, so it needs one bit more than a word index
  localparam logic [WORD_W:0]   ISSUE_END = (WORD_W + 1)'(WORDS);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);
  localparam logic [15:0]       BLOCK_MASK = ~16'((1 << OFFSET_W) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    FILL = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant decision: write-through first, then round-robin
// between the I and D fill requests using the previous fill owner.
module mem_arb_pick
  import cache_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   d_wr_req,
  input  owner_t last_grant,
  output logic   grant_wr,
  output logic   grant_fill,
  output owner_t grant_owner
);

  always_comb begin
    grant_wr    = 1'b0;
    grant_fill  = 1'b0;
    grant_owner = OWN_I;
    if (d_wr_req) begin
      grant_wr = 1'b1;
    end else if (i_req && d_req) begin
      grant_fill  = 1'b1;
      grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (i_req) begin
      grant_fill  = 1'b1;
      grant_owner = OWN_I;
    end else if (d_req) begin
      grant_fill  = 1'b1;
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory4c between I-fill, D-fill and D write-through:
// issues 8 word reads per fill and steers returning words to the owning cache.
module mem_arbiter
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_done,
  output logic        d_done,
  output logic        d_wr_ack,
  output logic        fsm_busy
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_grant_q, last_grant_d;
  logic [15:0]       base_q, base_d;
  logic [WORD_W:0]   issue_cnt_q, issue_cnt_d;
  logic [WORD_W-1:0] ret_cnt_q, ret_cnt_d;

  logic   grant_wr, grant_fill;
  owner_t grant_owner;
  logic   issuing, fill_v;

  mem_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .d_wr_req    (d_wr_req),
    .last_grant  (last_grant_q),
    .grant_wr    (grant_wr),
    .grant_fill  (grant_fill),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_grant_q <= OWN_I;
      base_q       <= 16'h0000;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
    end
  end

  assign issuing = (state_q == FILL) && (issue_cnt_q != ISSUE_END);
  // Returns are only meaningful while a fill owns the memory
  assign fill_v  = (state_q == FILL) && mem_valid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d = WR;
        end else if (grant_fill) begin
          state_d      = FILL;
          owner_d      = grant_owner;
          last_grant_d = grant_owner;
          base_d       = ((grant_owner == OWN_D) ? d_addr : i_addr) & BLOCK_MASK;
          issue_cnt_d  = '0;
          ret_cnt_d    = '0;
        end
      end
      WR: state_d = IDLE;
      FILL: begin
        if (issuing) issue_cnt_d = issue_cnt_q + 1'b1;
        if (mem_valid) begin
          ret_cnt_d = ret_cnt_q + 1'b1;
          if (ret_cnt_q == WORD_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = 16'h0000;
    mem_data_in = 16'h0000;
    d_wr_ack    = 1'b0;
    if (state_q == WR) begin
      mem_en      = 1'b1;
      mem_wr      = 1'b1;
      mem_addr    = d_wr_addr;
      mem_data_in = d_wr_data;
      d_wr_ack    = 1'b1;
    end else if (issuing) begin
      mem_en   = 1'b1;
      mem_addr = base_q + {12'h000, issue_cnt_q[WORD_W-1:0], 1'b0};
    end
  end

  assign fill_data = fill_v ? mem_data_out : 16'h0000;
  assign fill_word = fill_v ? ret_cnt_q : 3'd0;
  assign i_fill_we = fill_v && (owner_q == OWN_I);
  assign d_fill_we = fill_v && (owner_q == OWN_D);
  assign i_done    = i_fill_we && (ret_cnt_q == WORD_LAST);
  assign d_done    = d_fill_we && (ret_cnt_q == WORD_LAST);
  assign fsm_busy  = (state_q != IDLE);

endmodule
